// File: rtl/npc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : npc_pkg
//  Description : Shared types and constants for the NPC core fetch path:
//                fetch sequencer state encoding, fault cause codes, bus
//                response codes and the architectural reset vector.
//  Revision    : 1.0 - initial release
// ============================================================================
package npc_pkg;

  // Fetch sequencer states; one instruction in flight at a time
  typedef enum logic [2:0] {
    ST_BOOT   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT_R = 3'd2,
    ST_DISP   = 3'd3,
    ST_WAIT_C = 3'd4,
    ST_HALT   = 3'd5,
    ST_FAULT  = 3'd6
  } fetch_state_t;

  // Fault cause codes reported on err_cause
  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_BUS      = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_MISALIGN = 2'b11;

  // Read response code for a successful beat
  localparam logic [1:0] RESP_OKAY = 2'b00;

  // PC value held by the PC register out of reset
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  // Instructions are 32-bit words; the two low address bits must be zero
  function automatic logic is_word_aligned(input logic [1:0] addr_lo);
    return (addr_lo == 2'b00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ifu_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ifu_fetch_ctrl
//  Description : Multi-cycle fetch sequencer. Issues one instruction-memory
//                read per instruction, hands the word to the decoder, waits
//                for the execute unit to commit, then writes the committed
//                next PC into the PC register. Faults are sticky until reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module ifu_fetch_ctrl
  import npc_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  // PC register interface
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_wen,
  output logic [ADDR_W-1:0] pc_next,
  // Instruction memory read channels
  output logic              imem_arvalid,
  output logic [ADDR_W-1:0] imem_araddr,
  input  logic              imem_arready,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic [1:0]        imem_rresp,
  output logic              imem_rready,
  // Decoder handoff
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
  // Execute commit
  input  logic              commit_valid,
  input  logic [ADDR_W-1:0] commit_npc,
  input  logic              halt,
  // Fault reporting
  output logic              fetch_err,
  output logic [1:0]        err_cause
);

  // Wait counter wide enough to hold TIMEOUT itself
  localparam int             CTR_W     = $clog2(TIMEOUT + 1);
  localparam logic [CTR_W-1:0] c_timeout = CTR_W'(TIMEOUT);
  localparam logic [CTR_W-1:0] c_ctr_one = CTR_W'(1);

  fetch_state_t      r_state;
  logic [CTR_W-1:0]  r_ctr;
  logic              r_arvalid;
  logic [ADDR_W-1:0] r_araddr;
  logic              r_rready;
  logic              r_inst_valid;
  logic [DATA_W-1:0] r_inst;
  logic [ADDR_W-1:0] r_inst_pc;
  logic              r_fetch_err;
  logic [1:0]        r_err_cause;

  logic [CTR_W-1:0]  w_ctr_inc;
  logic              w_ctr_expired;
  logic              w_pc_wen;

  // Count of consecutive waited cycles including the current one
  assign w_ctr_inc     = r_ctr + c_ctr_one;
  assign w_ctr_expired = (w_ctr_inc == c_timeout);

  // The PC write happens in the very cycle EXU reports the commit, so the
  // PC register already holds the new value when the next fetch issues.
  assign w_pc_wen = rst_n && (r_state == ST_WAIT_C) && commit_valid;

  assign pc_wen       = w_pc_wen;
  assign pc_next      = w_pc_wen ? commit_npc : '0;
  assign imem_arvalid = r_arvalid;
  assign imem_araddr  = r_araddr;
  assign imem_rready  = r_rready;
  assign inst_valid   = r_inst_valid;
  assign inst         = r_inst;
  assign inst_pc      = r_inst_pc;
  assign fetch_err    = r_fetch_err;
  assign err_cause    = r_err_cause;

  // Fetch FSM with inline wait counter; every handshake output is registered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_BOOT;
      r_ctr        <= '0;
      r_arvalid    <= 1'b0;
      r_araddr     <= '0;
      r_rready     <= 1'b0;
      r_inst_valid <= 1'b0;
      r_inst       <= '0;
      r_inst_pc    <= '0;
      r_fetch_err  <= 1'b0;
      r_err_cause  <= ERR_NONE;
    end else begin
      case (r_state)
        // PC register has settled on the reset vector; latch it and
        // request only if it is word aligned (ISSUE faults otherwise).
        ST_BOOT: begin
          r_state   <= ST_ISSUE;
          r_ctr     <= '0;
          r_araddr  <= pc;
          r_arvalid <= is_word_aligned(pc[1:0]);
        end

        // Address phase; the read channel is not accepted here, so a
        // coincident rvalid is never consumed.
        ST_ISSUE: begin
          if (!is_word_aligned(r_araddr[1:0])) begin
            r_state     <= ST_FAULT;
            r_arvalid   <= 1'b0;
            r_fetch_err <= 1'b1;
            r_err_cause <= ERR_MISALIGN;
          end else if (imem_arready) begin
            r_state   <= ST_WAIT_R;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_ctr     <= '0;
          end else if (w_ctr_expired) begin
            r_state     <= ST_FAULT;
            r_arvalid   <= 1'b0;
            r_fetch_err <= 1'b1;
            r_err_cause <= ERR_TIMEOUT;
          end else begin
            r_ctr <= w_ctr_inc;
          end
        end

        // Data phase
        ST_WAIT_R: begin
          if (imem_rvalid) begin
            r_rready <= 1'b0;
            r_ctr    <= '0;
            if (imem_rresp == RESP_OKAY) begin
              r_state      <= ST_DISP;
              r_inst       <= imem_rdata;
              r_inst_pc    <= r_araddr;
              r_inst_valid <= 1'b1;
            end else begin
              r_state     <= ST_FAULT;
              r_fetch_err <= 1'b1;
              r_err_cause <= ERR_BUS;
            end
          end else if (w_ctr_expired) begin
            r_state     <= ST_FAULT;
            r_rready    <= 1'b0;
            r_fetch_err <= 1'b1;
            r_err_cause <= ERR_TIMEOUT;
          end else begin
            r_ctr <= w_ctr_inc;
          end
        end

        // Hold the instruction until the decoder takes it
        ST_DISP: begin
          if (inst_ready) begin
            r_state      <= ST_WAIT_C;
            r_inst_valid <= 1'b0;
            r_inst       <= '0;
            r_inst_pc    <= '0;
          end
        end

        // The next fetch address is the committed PC, which is exactly
        // what the PC register loads on this edge.
        ST_WAIT_C: begin
          if (commit_valid) begin
            r_ctr <= '0;
            if (halt) begin
              r_state <= ST_HALT;
            end else begin
              r_state   <= ST_ISSUE;
              r_araddr  <= commit_npc;
              r_arvalid <= is_word_aligned(commit_npc[1:0]);
            end
          end
        end

        // Terminal states; only reset leaves them
        ST_HALT:  r_state <= ST_HALT;
        ST_FAULT: r_state <= ST_FAULT;

        default: begin
          r_state      <= ST_BOOT;
          r_arvalid    <= 1'b0;
          r_rready     <= 1'b0;
          r_inst_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ifu_fetch_ctrl
//  Description : Directed self-checking bench for ifu_fetch_ctrl. Models the
//                external PC register and steps the fetch sequencer through
//                straight-line fetch, backpressure, faults, halt and a reset
//                in the middle of a read.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ifu_fetch_ctrl;
  import npc_pkg::*;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMEOUT = 8;

  logic              clk;
  logic              rst_n;
  logic [ADDR_W-1:0] pc;
  logic              pc_wen;
  logic [ADDR_W-1:0] pc_next;
  logic              imem_arvalid;
  logic [ADDR_W-1:0] imem_araddr;
  logic              imem_arready;
  logic              imem_rvalid;
  logic [DATA_W-1:0] imem_rdata;
  logic [1:0]        imem_rresp;
  logic              imem_rready;
  logic              inst_valid;
  logic [DATA_W-1:0] inst;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_ready;
  logic              commit_valid;
  logic [ADDR_W-1:0] commit_npc;
  logic              halt;
  logic              fetch_err;
  logic [1:0]        err_cause;

  logic [ADDR_W-1:0] pc_rst;
  int checks = 0;
  int errors = 0;
  int n_ar   = 0;
  int n_wen  = 0;

  ifu_fetch_ctrl #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc          (pc),
    .pc_wen      (pc_wen),
    .pc_next     (pc_next),
    .imem_arvalid(imem_arvalid),
    .imem_araddr (imem_araddr),
    .imem_arready(imem_arready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .imem_rresp  (imem_rresp),
    .imem_rready (imem_rready),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready),
    .commit_valid(commit_valid),
    .commit_npc  (commit_npc),
    .halt        (halt),
    .fetch_err   (fetch_err),
    .err_cause   (err_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External PC register, written only through pc_wen
  always @(posedge clk) begin
    if (!rst_n) pc <= pc_rst;
    else if (pc_wen) pc <= pc_next;
  end

  // Handshake counters
  always @(posedge clk) begin
    if (rst_n && imem_arvalid && imem_arready) n_ar <= n_ar + 1;
    if (pc_wen) n_wen <= n_wen + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [ADDR_W-1:0] rv);
    imem_arready = 1'b0;
    imem_rvalid  = 1'b0;
    imem_rdata   = '0;
    imem_rresp   = RESP_OKAY;
    inst_ready   = 1'b0;
    commit_valid = 1'b0;
    commit_npc   = '0;
    halt         = 1'b0;
    pc_rst       = rv;
    rst_n        = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(RESET_PC);
    checks++;
    if ({pc_wen, imem_arvalid, imem_rready, inst_valid, fetch_err, err_cause} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0000000",
               {pc_wen, imem_arvalid, imem_rready, inst_valid, fetch_err, err_cause});
    end
    checks++;
    if ({imem_araddr, inst, inst_pc, pc_next} !== 128'h0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0", {imem_araddr, inst, inst_pc, pc_next});
    end
    tick();
    checks++;
    if (imem_arvalid !== 1'b1 || imem_araddr !== 32'h8000_0000) begin
      errors++;
      $display("FAIL reset_first_ar: got arvalid=%b araddr=%h expected 1 80000000",
               imem_arvalid, imem_araddr);
    end
    checks++;
    if ({pc_wen, imem_rready, inst_valid, fetch_err} !== 4'b0) begin
      errors++;
      $display("FAIL reset_issue_others: got %b expected 0000",
               {pc_wen, imem_rready, inst_valid, fetch_err});
    end
  endtask

  task automatic test_straight();
    int wen0;
    imem_arready = 1'b1;
    tick();
    imem_arready = 1'b0;
    checks++;
    if ({imem_arvalid, imem_rready} !== 2'b01) begin
      errors++;
      $display("FAIL straight_wait_r: got arvalid,rready=%b expected 01", {imem_arvalid, imem_rready});
    end
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0000_0413;
    imem_rresp  = RESP_OKAY;
    tick();
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    checks++;
    if (inst_valid !== 1'b1 || inst !== 32'h0000_0413 || inst_pc !== 32'h8000_0000) begin
      errors++;
      $display("FAIL straight_disp: got v=%b inst=%h pc=%h expected 1 00000413 80000000",
               inst_valid, inst, inst_pc);
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    checks++;
    if (inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL straight_accept: got inst_valid=%b expected 0", inst_valid);
    end
    wen0 = n_wen;
    commit_valid = 1'b1;
    commit_npc   = 32'h8000_0004;
    #1;
    checks++;
    if (pc_wen !== 1'b1 || pc_next !== 32'h8000_0004) begin
      errors++;
      $display("FAIL straight_commit: got pc_wen=%b pc_next=%h expected 1 80000004", pc_wen, pc_next);
    end
    tick();
    commit_valid = 1'b0;
    commit_npc   = '0;
    checks++;
    if (pc_wen !== 1'b0 || n_wen - wen0 !== 1) begin
      errors++;
      $display("FAIL straight_wen_pulse: got pc_wen=%b pulses=%0d expected 0 1", pc_wen, n_wen - wen0);
    end
    checks++;
    if (imem_arvalid !== 1'b1 || imem_araddr !== 32'h8000_0004) begin
      errors++;
      $display("FAIL straight_next_ar: got arvalid=%b araddr=%h expected 1 80000004",
               imem_arvalid, imem_araddr);
    end
  endtask

  task automatic test_backpressure();
    int ar0;
    int wen0;
    ar0  = n_ar;
    wen0 = n_wen;
    // Stray error beat while the address phase stalls must be ignored
    imem_rvalid = 1'b1;
    imem_rresp  = 2'b10;
    imem_rdata  = 32'hBAD0_BAD0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({imem_arvalid, imem_rready, fetch_err} !== 3'b100 || imem_araddr !== 32'h8000_0004) begin
        errors++;
        $display("FAIL bp_ar_hold[%0d]: got arvalid,rready,err=%b araddr=%h expected 100 80000004",
                 i, {imem_arvalid, imem_rready, fetch_err}, imem_araddr);
      end
    end
    imem_arready = 1'b1;
    tick();
    imem_arready = 1'b0;
    imem_rvalid  = 1'b0;
    imem_rresp   = RESP_OKAY;
    imem_rdata   = '0;
    checks++;
    if (imem_rready !== 1'b1 || fetch_err !== 1'b0 || n_ar - ar0 !== 1) begin
      errors++;
      $display("FAIL bp_ar_accept: got rready=%b err=%b requests=%0d expected 1 0 1",
               imem_rready, fetch_err, n_ar - ar0);
    end
    tick();
    checks++;
    if (imem_rready !== 1'b1 || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_r_wait: got rready=%b inst_valid=%b expected 1 0", imem_rready, inst_valid);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0010_0093;
    tick();
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    // Commit outside WAIT_C must not touch the PC
    commit_valid = 1'b1;
    commit_npc   = 32'hFFFF_FFF0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (inst_valid !== 1'b1 || inst !== 32'h0010_0093 || inst_pc !== 32'h8000_0004 || pc_wen !== 1'b0) begin
        errors++;
        $display("FAIL bp_disp_hold[%0d]: got v=%b inst=%h pc=%h wen=%b expected 1 00100093 80000004 0",
                 i, inst_valid, inst, inst_pc, pc_wen);
      end
      tick();
    end
    commit_valid = 1'b0;
    commit_npc   = '0;
    inst_ready   = 1'b1;
    tick();
    inst_ready = 1'b0;
    tick();
    checks++;
    if (pc_wen !== 1'b0 || n_wen - wen0 !== 0 || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_exu_wait: got wen=%b pulses=%0d inst_valid=%b expected 0 0 0",
               pc_wen, n_wen - wen0, inst_valid);
    end
    commit_valid = 1'b1;
    commit_npc   = 32'h8000_0008;
    #1;
    checks++;
    if (pc_wen !== 1'b1 || pc_next !== 32'h8000_0008) begin
      errors++;
      $display("FAIL bp_commit: got pc_wen=%b pc_next=%h expected 1 80000008", pc_wen, pc_next);
    end
    tick();
    commit_valid = 1'b0;
    commit_npc   = '0;
    checks++;
    if (n_wen - wen0 !== 1 || n_ar - ar0 !== 1 || imem_arvalid !== 1'b1 || imem_araddr !== 32'h8000_0008) begin
      errors++;
      $display("FAIL bp_totals: got pulses=%0d requests=%0d arvalid=%b araddr=%h expected 1 1 1 80000008",
               n_wen - wen0, n_ar - ar0, imem_arvalid, imem_araddr);
    end
  endtask

  task automatic test_halt();
    int ar0;
    int wen0;
    int bad;
    imem_arready = 1'b1;
    tick();
    imem_arready = 1'b0;
    imem_rvalid  = 1'b1;
    imem_rdata   = 32'h0010_0073;
    tick();
    imem_rvalid = 1'b0;
    checks++;
    if (inst_valid !== 1'b1 || inst !== 32'h0010_0073 || inst_pc !== 32'h8000_0008) begin
      errors++;
      $display("FAIL halt_disp: got v=%b inst=%h pc=%h expected 1 00100073 80000008",
               inst_valid, inst, inst_pc);
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    ar0  = n_ar;
    wen0 = n_wen;
    commit_valid = 1'b1;
    halt         = 1'b1;
    commit_npc   = 32'h8000_0010;
    #1;
    checks++;
    if (pc_wen !== 1'b1 || pc_next !== 32'h8000_0010) begin
      errors++;
      $display("FAIL halt_commit: got pc_wen=%b pc_next=%h expected 1 80000010", pc_wen, pc_next);
    end
    tick();
    halt         = 1'b0;
    imem_arready = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (imem_arvalid || imem_rready || inst_valid || pc_wen) bad++;
    end
    imem_arready = 1'b0;
    commit_valid = 1'b0;
    commit_npc   = '0;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL halt_idle: got %0d active cycles expected 0", bad);
    end
    checks++;
    if (n_wen - wen0 !== 1 || n_ar - ar0 !== 0) begin
      errors++;
      $display("FAIL halt_counts: got pulses=%0d requests=%0d expected 1 0", n_wen - wen0, n_ar - ar0);
    end
    checks++;
    if (pc !== 32'h8000_0010) begin
      errors++;
      $display("FAIL halt_pc: got %h expected 80000010", pc);
    end
  endtask

  task automatic test_errors();
    // Bus error on the read response
    do_reset(RESET_PC);
    tick();
    imem_arready = 1'b1;
    tick();
    imem_arready = 1'b0;
    imem_rvalid  = 1'b1;
    imem_rresp   = 2'b10;
    tick();
    imem_rvalid = 1'b0;
    imem_rresp  = RESP_OKAY;
    checks++;
    if (fetch_err !== 1'b1 || err_cause !== 2'b01 || {imem_arvalid, imem_rready, inst_valid} !== 3'b0) begin
      errors++;
      $display("FAIL err_bus: got err=%b cause=%b ar,r,iv=%b expected 1 01 000",
               fetch_err, err_cause, {imem_arvalid, imem_rready, inst_valid});
    end
    imem_arready = 1'b1;
    tick();
    tick();
    tick();
    imem_arready = 1'b0;
    checks++;
    if (fetch_err !== 1'b1 || err_cause !== 2'b01 || imem_arvalid !== 1'b0) begin
      errors++;
      $display("FAIL err_sticky: got err=%b cause=%b arvalid=%b expected 1 01 0",
               fetch_err, err_cause, imem_arvalid);
    end

    // Misaligned reset vector
    do_reset(32'h8000_0002);
    tick();
    checks++;
    if (imem_arvalid !== 1'b0) begin
      errors++;
      $display("FAIL err_misalign_noar: got arvalid=%b expected 0", imem_arvalid);
    end
    tick();
    checks++;
    if (fetch_err !== 1'b1 || err_cause !== 2'b11 || imem_arvalid !== 1'b0) begin
      errors++;
      $display("FAIL err_misalign: got err=%b cause=%b arvalid=%b expected 1 11 0",
               fetch_err, err_cause, imem_arvalid);
    end

    // Read data never arrives
    do_reset(RESET_PC);
    tick();
    imem_arready = 1'b1;
    tick();
    imem_arready = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if (fetch_err !== 1'b0 || imem_rready !== 1'b1) begin
      errors++;
      $display("FAIL err_timeout_early: got err=%b rready=%b expected 0 1", fetch_err, imem_rready);
    end
    tick();
    checks++;
    if (fetch_err !== 1'b1 || err_cause !== 2'b10 || imem_rready !== 1'b0) begin
      errors++;
      $display("FAIL err_timeout: got err=%b cause=%b rready=%b expected 1 10 0",
               fetch_err, err_cause, imem_rready);
    end
  endtask

  task automatic test_reset_midflight();
    do_reset(RESET_PC);
    tick();
    imem_arready = 1'b1;
    tick();
    imem_arready = 1'b0;
    checks++;
    if (imem_rready !== 1'b1) begin
      errors++;
      $display("FAIL mid_wait_r: got rready=%b expected 1", imem_rready);
    end
    rst_n = 1'b0;
    tick();
    rst_n       = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    imem_rresp  = RESP_OKAY;
    #1;
    checks++;
    if ({imem_rready, imem_arvalid, inst_valid} !== 3'b000) begin
      errors++;
      $display("FAIL mid_after_reset: got rready,arvalid,iv=%b expected 000",
               {imem_rready, imem_arvalid, inst_valid});
    end
    tick();
    checks++;
    if (imem_arvalid !== 1'b1 || imem_araddr !== 32'h8000_0000 || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_refetch: got arvalid=%b araddr=%h iv=%b expected 1 80000000 0",
               imem_arvalid, imem_araddr, inst_valid);
    end
    tick();
    checks++;
    if ({inst_valid, imem_rready, fetch_err} !== 3'b000 || imem_arvalid !== 1'b1) begin
      errors++;
      $display("FAIL mid_late_rvalid: got iv,rready,err=%b arvalid=%b expected 000 1",
               {inst_valid, imem_rready, fetch_err}, imem_arvalid);
    end
    imem_rvalid  = 1'b0;
    imem_arready = 1'b1;
    tick();
    imem_arready = 1'b0;
    imem_rvalid  = 1'b1;
    imem_rdata   = 32'h0000_0513;
    tick();
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    checks++;
    if (inst_valid !== 1'b1 || inst !== 32'h0000_0513 || inst_pc !== 32'h8000_0000) begin
      errors++;
      $display("FAIL mid_fresh_inst: got v=%b inst=%h pc=%h expected 1 00000513 80000000",
               inst_valid, inst, inst_pc);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    pc_rst       = RESET_PC;
    imem_arready = 1'b0;
    imem_rvalid  = 1'b0;
    imem_rdata   = '0;
    imem_rresp   = RESP_OKAY;
    inst_ready   = 1'b0;
    commit_valid = 1'b0;
    commit_npc   = '0;
    halt         = 1'b0;
    test_reset();
    test_straight();
    test_backpressure();
    test_halt();
    test_errors();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000 ns expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
